// File: rtl/prefetch_queue_pkg.sv
// Shared fetch-path definitions: word width, the NOP encoding, fetch FSM states
// and the {pc, instr} queue entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0: what decode sees when no instruction is offered
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h00000013;

  // IDLE: no request outstanding; REQ: request outstanding, data wanted;
  // DROP: request outstanding but its data is stale after a redirect
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo_mem.sv
// Storage array for the prefetch queue: DEPTH entries of {pc, instr}.
// Latency: write lands at the clock edge; read is combinational from rd_addr_i.
// Backpressure: none here; the parent only writes when it has room.
// Ports: clk; wr_en_i/wr_addr_i/wr_dat_i write port; rd_addr_i/rd_dat_o read port.
module prefetch_fifo_mem
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  fetch_entry_t wr_dat_i,
  input  logic [AW-1:0] rd_addr_i,
  output fetch_entry_t rd_dat_o
);

  // No reset: contents are only observed once the parent's count says valid
  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch front end: sequential imem fetches into a DEPTH-entry queue
// feeding the fetch slot; jmp flushes the queue and redirects fetch.
// Latency: acked word visible on f_* one cycle after ack (same cycle when
// PREFETCH_BYPASS_EN is defined and the queue is empty). Backpressure: head held
// while hazard or !d_ready; requests stop when the queue has no room.
// Ports: clk, rst (async, active high); imem_req/imem_addr/imem_ack/imem_data fetch
// handshake; f_instr/f_pc/f_valid head of queue; hazard, d_ready pop control;
// jmp/jmp_addr redirect. Optional macro: PREFETCH_BYPASS_EN.
module prefetch_queue
  import riscv_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc,
  output logic        f_valid,
  input  logic        hazard,
  input  logic        d_ready,
  input  logic        jmp,
  input  logic [31:0] jmp_addr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   redirect_pc_q, redirect_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;

  fetch_entry_t  head_dat;
  fetch_entry_t  wr_dat;
  logic          q_empty;
  logic          fetch_ok;
  logic          byp_vld;
  logic          pop;
  logic          pop_q;
  logic          push;
  logic          room;

  assign q_empty  = (count_q == '0);
  // A wanted word arrives; a coincident jmp makes it stale
  assign fetch_ok = (state_q == REQ) && imem_ack && !jmp;

`ifdef PREFETCH_BYPASS_EN
  assign byp_vld = q_empty && fetch_ok;
`else
  assign byp_vld = 1'b0;
`endif

  assign f_valid = !q_empty || byp_vld;
  assign pop     = f_valid && !hazard && d_ready && !jmp;
  // Only a pop of a stored entry moves the read side
  assign pop_q   = pop && !q_empty;
  // A bypassed word consumed in its ack cycle never needs storing
  assign push    = fetch_ok && !(byp_vld && pop);

  always_comb begin
    f_instr = INSTR_NOP;
    f_pc    = fetch_pc_q;
    if (byp_vld) begin
      f_instr = imem_data;
      f_pc    = fetch_pc_q;
    end else if (!q_empty) begin
      f_instr = head_dat.instr;
      f_pc    = head_dat.pc;
    end
  end

  // jmp flushes the queue outright, overriding any push or pop this cycle
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (jmp) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop_q);
      if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_q) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  assign room = (count_d < DEPTH_C);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (jmp) begin
          fetch_pc_d = jmp_addr;
          state_d    = REQ;
        end else if (room) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (jmp) begin
            fetch_pc_d = jmp_addr;
            state_d    = REQ;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = room ? REQ : IDLE;
          end
        end else if (jmp) begin
          // The address must stay stable until the ack, so park the target
          redirect_pc_d = jmp_addr;
          state_d       = DROP;
        end
      end
      DROP: begin
        if (jmp) begin
          redirect_pc_d = jmp_addr;
        end
        if (imem_ack) begin
          fetch_pc_d = jmp ? jmp_addr : redirect_pc_q;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = fetch_pc_q;

  assign wr_dat.pc    = fetch_pc_q;
  assign wr_dat.instr = imem_data;

  prefetch_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_dat_i  (wr_dat),
    .rd_addr_i (rd_ptr_q),
    .rd_dat_o  (head_dat)
  );

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: table of per-cycle vectors plus hand sequences
// for async reset mid-request and the bypass/no-bypass ack cycle.
// Inputs change on the falling edge; outputs are sampled 2 time units later.
module tb_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        f_valid;
  logic        hazard = 1'b0;
  logic        d_ready = 1'b1;
  logic        jmp = 1'b0;
  logic [31:0] jmp_addr = 32'h0;

  logic        use_fixed = 1'b0;
  logic [31:0] fixed_data = 32'h0;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] PAT = 32'hA5A5A5A5;

  // Memory model: word at an address is the address XOR a fixed pattern
  assign imem_data = use_fixed ? fixed_data : (imem_addr ^ PAT);

  always #5 clk = ~clk;

  prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h00000000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_addr (imem_addr),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .f_instr   (f_instr),
    .f_pc      (f_pc),
    .f_valid   (f_valid),
    .hazard    (hazard),
    .d_ready   (d_ready),
    .jmp       (jmp),
    .jmp_addr  (jmp_addr)
  );

  typedef struct {
    logic        rst;
    logic        ack;
    logic        hz;
    logic        dr;
    logic        jmp;
    logic [31:0] ja;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] epc;
  } vec_t;

  vec_t vec[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic r(input logic rst_v, input logic ack, input logic hz, input logic dr,
                   input logic jp, input logic [31:0] ja, input logic ereq,
                   input logic [31:0] eaddr, input logic evld, input logic [31:0] epc);
    vec_t v;
    v.rst = rst_v; v.ack = ack; v.hz = hz; v.dr = dr; v.jmp = jp; v.ja = ja;
    v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.epc = epc;
    vec.push_back(v);
  endtask

  // f_pc is only meaningful while f_valid, so it is checked only then
  task automatic check_slot(input string tag, input logic ereq, input logic [31:0] eaddr,
                            input logic evld, input logic [31:0] epc,
                            input logic [31:0] einstr);
    chk({tag, " imem_req"}, {31'b0, imem_req}, {31'b0, ereq});
    chk({tag, " imem_addr"}, imem_addr, eaddr);
    chk({tag, " f_valid"}, {31'b0, f_valid}, {31'b0, evld});
    chk({tag, " f_instr"}, f_instr, evld ? einstr : NOP);
    if (evld) chk({tag, " f_pc"}, f_pc, epc);
  endtask

  task automatic run_table();
    for (int i = 0; i < vec.size(); i++) begin
      @(negedge clk);
      rst      = vec[i].rst;
      imem_ack = vec[i].ack;
      hazard   = vec[i].hz;
      d_ready  = vec[i].dr;
      jmp      = vec[i].jmp;
      jmp_addr = vec[i].ja;
      #2;
      check_slot($sformatf("row%0d", i), vec[i].ereq, vec[i].eaddr, vec[i].evld,
                 vec[i].epc, vec[i].epc ^ PAT);
    end
    vec.delete();
  endtask

  initial begin
`ifndef PREFETCH_BYPASS_EN
    // Streaming from reset, then a 10-cycle hazard stall filling the queue
    r(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    r(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    r(0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    for (int k = 2; k <= 4; k++)   r(0, 1, 0, 1, 0, 0, 1, 4*(k-1), 1, 4*(k-2));
    for (int k = 5; k <= 7; k++)   r(0, 1, 1, 1, 0, 0, 1, 4*(k-1), 1, 12);
    for (int k = 8; k <= 14; k++)  r(0, 1, 1, 1, 0, 0, 0, 28, 1, 12);
    r(0, 1, 0, 1, 0, 0, 0, 28, 1, 12);
    for (int k = 16; k <= 20; k++) r(0, 1, 0, 1, 0, 0, 1, 4*(k-9), 1, 4*k-48);

    // jmp while the request to 0x10 waits for a late ack, then jmp on an ack
    r(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    r(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    r(0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    for (int k = 2; k <= 4; k++)   r(0, 1, 0, 1, 0, 0, 1, 4*(k-1), 1, 4*(k-2));
    r(0, 0, 0, 1, 1, 32'h100, 1, 32'h10, 1, 32'hc);
    r(0, 0, 0, 1, 0, 0, 1, 32'h10, 0, 0);
    r(0, 0, 0, 1, 0, 0, 1, 32'h10, 0, 0);
    r(0, 1, 0, 1, 0, 0, 1, 32'h10, 0, 0);
    r(0, 1, 0, 1, 0, 0, 1, 32'h100, 0, 0);
    r(0, 1, 0, 1, 0, 0, 1, 32'h104, 1, 32'h100);
    r(0, 1, 0, 1, 1, 32'h200, 1, 32'h108, 1, 32'h104);
    r(0, 1, 0, 1, 0, 0, 1, 32'h200, 0, 0);
    r(0, 1, 0, 1, 0, 0, 1, 32'h204, 1, 32'h200);

    // Fill to count 3 under hazard with a request still pending
    r(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    r(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    r(0, 1, 1, 1, 0, 0, 1, 0, 0, 0);
    r(0, 1, 1, 1, 0, 0, 1, 4, 1, 0);
    r(0, 1, 1, 1, 0, 0, 1, 8, 1, 0);
    r(0, 0, 1, 1, 0, 0, 1, 32'hc, 1, 0);
    run_table();

    // Async reset between clock edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_slot("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0; hazard = 1'b0; imem_ack = 1'b1;
    #2 check_slot("restart0", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #2 check_slot("restart1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #2 check_slot("restart2", 1'b1, 32'h4, 1'b1, 32'h0, PAT);
`else
    r(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    run_table();
`endif

    // Single ack into an empty queue with decode ready
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; hazard = 1'b0; d_ready = 1'b1; jmp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    imem_ack = 1'b1; use_fixed = 1'b1; fixed_data = 32'hDEADBEEF;
`ifdef PREFETCH_BYPASS_EN
    #2 check_slot("ack_cycle", 1'b1, 32'h0, 1'b1, 32'h0, 32'hDEADBEEF);
    @(negedge clk);
    imem_ack = 1'b0;
    #2 check_slot("after_ack", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
`else
    #2 check_slot("ack_cycle", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    imem_ack = 1'b0;
    #2 check_slot("after_ack", 1'b1, 32'h4, 1'b1, 32'h0, 32'hDEADBEEF);
`endif
    @(negedge clk);
    #2 check_slot("drained", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
